// File: rtl/rs_cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rs_cmd_pkg: shared debounce FSM encoding and default constants     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rs_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RISE_WAIT = 2'd1,
      HIGH      = 2'd2,
      FALL_WAIT = 2'd3
   } dbc_state_t;

   localparam int c_DEBOUNCE_CYCLES = 4;

endpackage : rs_cmd_pkg
`default_nettype wire

// File: rtl/rs_debounce_ch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rs_debounce_ch: optional 2-flop sync (RS_CMD_SYNC_EN) + debounce   |
// | FSM producing a debounced level and a one-cycle rising-edge flag.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rs_debounce_ch
   import rs_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic edge_q
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic             w_din;
   dbc_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_hit;
   logic             r_level;
   logic             r_edge;

`ifdef RS_CMD_SYNC_EN
   logic [1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], din};
      end
   end

   assign w_din = r_sync[1];
`else
   assign w_din = din;
`endif

   // Saturating increment; w_hit means this sample completes the stable run.
   assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? c_CNT_MAX : r_cnt + CNT_W'(1);
   assign w_hit     = (w_cnt_inc == c_CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_edge  <= 1'b0;
      end else begin
         r_edge <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_din) begin
                  if (w_hit) begin
                     r_state <= HIGH;
                     r_cnt   <= '0;
                     r_level <= 1'b1;
                     r_edge  <= 1'b1;
                  end else begin
                     r_state <= RISE_WAIT;
                     r_cnt   <= w_cnt_inc;
                  end
               end
            end
            RISE_WAIT: begin
               if (!w_din) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (w_hit) begin
                  r_state <= HIGH;
                  r_cnt   <= '0;
                  r_level <= 1'b1;
                  r_edge  <= 1'b1;
               end else begin
                  r_cnt   <= w_cnt_inc;
               end
            end
            HIGH: begin
               if (!w_din) begin
                  if (w_hit) begin
                     r_state <= IDLE;
                     r_cnt   <= '0;
                     r_level <= 1'b0;
                  end else begin
                     r_state <= FALL_WAIT;
                     r_cnt   <= w_cnt_inc;
                  end
               end
            end
            FALL_WAIT: begin
               if (w_din) begin
                  r_state <= HIGH;
                  r_cnt   <= '0;
               end else if (w_hit) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_level <= 1'b0;
               end else begin
                  r_cnt   <= w_cnt_inc;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_level <= 1'b0;
            end
         endcase
      end
   end

   assign level  = r_level;
   assign edge_q = r_edge;

endmodule : rs_debounce_ch
`default_nettype wire

// File: rtl/rs_cmd_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rs_cmd_gen: debounced set/clear strobes for rs_ff, clear wins.     |
// | Synchroniser selected by RS_CMD_SYNC_EN.  Rev 1.0                  |
// +--------------------------------------------------------------------+
module rs_cmd_gen
   import rs_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic set_in,
   input  logic clr_in,
   output logic s,
   output logic r,
   output logic conflict,
   output logic set_level,
   output logic clr_level
);

   logic w_set_edge;
   logic w_clr_edge;
   logic w_set_lvl;
   logic w_clr_lvl;

   logic r_s;
   logic r_r;
   logic r_conflict;
   logic r_set_level;
   logic r_clr_level;

   rs_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_set_ch (
      .clk    (clk),
      .rst    (rst),
      .din    (set_in),
      .level  (w_set_lvl),
      .edge_q (w_set_edge)
   );

   rs_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_clr_ch (
      .clk    (clk),
      .rst    (rst),
      .din    (clr_in),
      .level  (w_clr_lvl),
      .edge_q (w_clr_edge)
   );

   // Clear has priority; a set colliding with a clear is dropped, not held.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s         <= 1'b0;
         r_r         <= 1'b0;
         r_conflict  <= 1'b0;
         r_set_level <= 1'b0;
         r_clr_level <= 1'b0;
      end else begin
         r_s         <= w_set_edge & ~w_clr_edge;
         r_r         <= w_clr_edge;
         r_conflict  <= w_set_edge & w_clr_edge;
         r_set_level <= w_set_lvl;
         r_clr_level <= w_clr_lvl;
      end
   end

   assign s         = r_s;
   assign r         = r_r;
   assign conflict  = r_conflict;
   assign set_level = r_set_level;
   assign clr_level = r_clr_level;

endmodule : rs_cmd_gen
`default_nettype wire

// File: tb/tb_rs_cmd_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rs_cmd_gen: directed + random stimulus, run-length reference    |
// | model feeding a scoreboard queue.  Rev 1.0                         |
// +--------------------------------------------------------------------+
module tb_rs_cmd_gen;

   localparam int c_D = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic set_in = 1'b0;
   logic clr_in = 1'b0;
   logic s, r, conflict, set_level, clr_level;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_s = 0, n_r = 0, n_cf = 0;

   // Expected {s, r, conflict, set_level, clr_level} for the cycle after each edge
   logic [4:0] exp_q[$];

   rs_cmd_gen #(.DEBOUNCE_CYCLES(c_D)) dut (
      .clk       (clk),
      .rst       (rst),
      .set_in    (set_in),
      .clr_in    (clr_in),
      .s         (s),
      .r         (r),
      .conflict  (conflict),
      .set_level (set_level),
      .clr_level (clr_level)
   );

   always #5 clk = ~clk;

   // Reference: a level flips once D consecutive samples disagree with it;
   // the resulting rising edge and new level appear one register later.
   initial begin : model
      bit lvl [2];
      int run [2];
      bit edg [2];
      bit p1  [2];
      bit p2  [2];
      bit raw [2];
      bit x;
      logic [4:0] e;
      for (int c = 0; c < 2; c++) begin
         lvl[c] = 0; run[c] = 0; edg[c] = 0; p1[c] = 0; p2[c] = 0;
      end
      forever begin
         @(posedge clk);
         raw[0] = set_in;
         raw[1] = clr_in;
         if (rst) begin
            for (int c = 0; c < 2; c++) begin
               lvl[c] = 0; run[c] = 0; edg[c] = 0; p1[c] = 0; p2[c] = 0;
            end
            e = 5'b0;
         end else begin
            e = {edg[0] & ~edg[1], edg[1], edg[0] & edg[1], lvl[0], lvl[1]};
            for (int c = 0; c < 2; c++) begin
`ifdef RS_CMD_SYNC_EN
               x     = p2[c];
               p2[c] = p1[c];
               p1[c] = raw[c];
`else
               x     = raw[c];
`endif
               edg[c] = 0;
               if (x != lvl[c]) begin
                  run[c]++;
                  if (run[c] == c_D) begin
                     lvl[c] = x;
                     run[c] = 0;
                     edg[c] = x;
                  end
               end else begin
                  run[c] = 0;
               end
            end
         end
         exp_q.push_back(e);
      end
   end

   initial begin : monitor
      logic [4:0] exp_v;
      logic [4:0] got;
      forever begin
         @(negedge clk);
         cyc++;
         got = {s, r, conflict, set_level, clr_level};
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty cyc=%0d got=%b required=an expected entry", cyc, got);
         end else begin
            exp_v = exp_q.pop_front();
            if (got !== exp_v) begin
               failures++;
               $display("FAIL outputs cyc=%0d {s,r,conflict,set_level,clr_level} got=%b required=%b",
                        cyc, got, exp_v);
            end
         end
         checks++;
         if ((s & r) !== 1'b0) begin
            failures++;
            $display("FAIL s_r_exclusive cyc=%0d s=%b r=%b required not both 1", cyc, s, r);
         end
         if (s === 1'b1) n_s++;
         if (r === 1'b1) n_r++;
         if (conflict === 1'b1) n_cf++;
      end
   end

   task automatic step(input bit a, input bit b, input int n);
      set_in = a;
      clr_in = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : stim
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      step(0, 0, 5);
      step(1, 0, 20);                     // clean set
      step(0, 0, 20);                     // release
      step(1, 1, 14);                     // simultaneous rise
      step(0, 0, 14);
      step(1, 0, 1);                      // staggered rise
      step(1, 1, 14);
      step(0, 0, 14);
      step(1, 0, 2);                      // bounce then settle
      step(0, 0, 1);
      step(1, 0, 14);
      step(0, 0, 14);
      step(1, 0, 3);                      // reset mid-debounce, input held high
      rst = 1'b1;
      step(1, 0, 2);
      rst = 1'b0;
      step(1, 0, 14);
      step(0, 0, 14);
      step(1, 0, 2);                      // short glitches below the threshold
      step(0, 0, 3);
      step(0, 1, 3);
      step(0, 0, 10);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(5) == 0) set_in = ~set_in;
         if ($urandom_range(5) == 0) clr_in = ~clr_in;
         rst = ($urandom_range(299) == 0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      step(0, 0, 20);
      checks++;
      if (n_s == 0 || n_r == 0 || n_cf == 0) begin
         failures++;
         $display("FAIL strobe_activity s_pulses=%0d r_pulses=%0d conflicts=%0d required all nonzero",
                  n_s, n_r, n_cf);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_rs_cmd_gen
`default_nettype wire

// File: doc/rs_cmd_gen.md
# rs_cmd_gen

Upstream command stage for the RS flip-flop (`rs_ff`). It takes two raw, possibly bouncing and asynchronous request lines, `set_in` and `clr_in`. It synchronises and debounces each line, then converts each debounced rising edge into a single-cycle strobe that drives the flip-flop's `s` and `r` inputs. It guarantees `s` and `r` are never asserted together, so the RS flip-flop never sees the forbidden S=R=1 input.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a level change. Legal range is ≥1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `set_in`  in  1  raw set request; may be asynchronous and may bounce.
- `clr_in`  in  1  raw clear request; may be asynchronous and may bounce.
- `s`  out  1  one-cycle set strobe, connects to `rs_ff.s`.
- `r`  out  1  one-cycle reset strobe, connects to `rs_ff.r`.
- `conflict`  out  1  one-cycle flag: both strobes qualified in the same cycle.
- `set_level`  out  1  debounced level of `set_in`.
- `clr_level`  out  1  debounced level of `clr_in`.

## Operation
- Each input has its own channel: an optional 2-flop synchroniser, then a debounce FSM with a counter.
- FSM states:
  - IDLE: stable low, counter 0.
  - RISE_WAIT: counting while the input is high.
  - HIGH: stable high.
  - FALL_WAIT: counting while the input is low.
- Transitions:
  - IDLE→RISE_WAIT when the synchronised input is 1. The counter loads 1.
  - In RISE_WAIT, input 1 increments the counter. When the counter reaches DEBOUNCE_CYCLES with the input still 1, go to HIGH and raise the channel's qualified-edge signal for one cycle. Input 0 returns to IDLE and clears the counter.
  - HIGH→FALL_WAIT when the input is 0. FALL_WAIT mirrors RISE_WAIT and ends in IDLE. No strobe on a fall.
  - Bounce during RISE_WAIT or FALL_WAIT restarts from the prior stable state. No partial credit is kept.
- The counter saturates at DEBOUNCE_CYCLES and never wraps.
- `set_level` is 1 in HIGH and FALL_WAIT, and 0 in IDLE and RISE_WAIT. `clr_level` follows the same rule.
- Arbitration is registered:
  - `s` = set_edge & ~clr_edge.
  - `r` = clr_edge.
  - `conflict` = set_edge & clr_edge.
  - Clear wins. A suppressed set strobe is dropped, not deferred.
- Edges in different cycles each produce their own strobe, with no minimum gap.
- Reset values are 0 for `s`, `r`, `conflict`, `set_level`, `clr_level`, all synchroniser flops and all counters. FSMs reset to IDLE.
- Reset mid-debounce discards progress and emits no strobe. An input held high through reset release is treated as a new rising edge after release.

## Timing
- The raw input is sampled at edge k.
- Synchronised value is visible at k+2 when the synchroniser is compiled in, otherwise at k.
- `s`, `r` and `conflict` are high exactly one cycle, at k+2+DEBOUNCE_CYCLES (k+DEBOUNCE_CYCLES without the synchroniser).
- `set_level` and `clr_level` change in the same cycle as the corresponding strobe would.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- Macro `RS_CMD_SYNC_EN`.
- Defined: each input passes through two flops before its FSM, and latency includes the +2 cycles.
- Undefined: the synchroniser is removed, inputs must be synchronous to `clk`, and latency drops by 2. Everything else is identical.

## Structure
- Shared package `rs_cmd_pkg` holds:
  - the FSM state encoding (IDLE=2'd0, RISE_WAIT=2'd1, HIGH=2'd2, FALL_WAIT=2'd3);
  - the `DEBOUNCE_CYCLES` default constant.
- Sub-module `rs_debounce_ch` is instantiated twice. Each instance contains the synchroniser, FSM and counter, and outputs `level` and `edge_q`.
- Arbitration and output registers live in `rs_cmd_gen`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 with `RS_CMD_SYNC_EN` defined; the pulse latency is 6 cycles.
- Clean set: `set_in` 0→1 sampled at cycle 10 → `s`=1 only in cycle 16. `r`=`conflict`=0 throughout. `set_level`=1 from cycle 16.
- Bounce: `set_in` high for 2 cycles, low for 1, then high from cycle 20 → exactly one `s` pulse, in cycle 26.
- Simultaneous: `set_in` and `clr_in` rise together at cycle 10 → `r`=1 and `conflict`=1 in cycle 16, and `s` stays 0.
- Staggered: `set_in` rises at cycle 10 and `clr_in` at cycle 11 → `s` in cycle 16, `r` in cycle 17, `conflict` 0. `s` and `r` are never both 1 at any time.
- Reset mid-debounce: `set_in` rises at cycle 10 and `rst` is high in cycles 13–14, with `set_in` held high → no strobe before cycle 15, all outputs 0 during reset, `s` pulse at cycle 21.
- Release: after the clean-set scenario, `set_in` falls at cycle 30 → `set_level`=0 at cycle 36. No `s`/`r` strobe.
